// File: rtl/instr_fetch_unit.sv
// PC/IR fetch stage: issues req/ack fetches to a variable-latency instruction memory.
// Optional macro FETCH_TIMEOUT_EN adds a WAIT-cycle watchdog and the sticky fetch_err flag.
module instr_fetch_unit #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PC_clr,
  input  logic               PC_inc,
  input  logic               PC_ld,
  input  logic [PC_W-1:0]    ld_addr,
  input  logic               I_rd,
  input  logic               IR_ld,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    pc,
  output logic               fetch_busy,
  output logic               fetch_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]         state;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic               inc_p, ld_p;
  logic               launch;

  // In WAIT the request stays up even during an abort; it drops the cycle after.
  assign launch      = (state == IDLE) & ~PC_clr & ~PC_ld & I_rd;
  assign imem_req    = (state == WAIT) | launch;
  assign fetch_busy  = imem_req & ~imem_ack;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = ir_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
  logic             err_q;
  assign fetch_err = err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign fetch_err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc_q  <= '0;
      ir_q  <= '0;
      inc_p <= 1'b0;
      ld_p  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt   <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (PC_clr) begin
            pc_q <= '0;
`ifdef FETCH_TIMEOUT_EN
            err_q <= 1'b0;
`endif
          end else if (PC_ld) begin
            pc_q <= ld_addr;
          end else if (I_rd) begin
            inc_p <= PC_inc;
            ld_p  <= IR_ld;
            if (imem_ack) begin
              if (IR_ld)  ir_q <= imem_rdata;
              if (PC_inc) pc_q <= pc_q + 1'b1;
            end else begin
              state <= WAIT;
`ifdef FETCH_TIMEOUT_EN
              cnt   <= '0;
`endif
            end
          end
        end
        default: begin
          if (PC_clr) begin
            pc_q  <= '0;
            state <= IDLE;
`ifdef FETCH_TIMEOUT_EN
            err_q <= 1'b0;
`endif
          end else if (imem_ack) begin
            if (ld_p)  ir_q <= imem_rdata;
            if (inc_p) pc_q <= pc_q + 1'b1;
            state <= IDLE;
          end
`ifdef FETCH_TIMEOUT_EN
          // Last permitted wait cycle without ack: force an all-ones opcode.
          else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            ir_q  <= '1;
            err_q <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_instr_fetch_unit;
  localparam int PC_W = 8, INSTR_W = 16, TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst, PC_clr, PC_inc, PC_ld, I_rd, IR_ld, imem_ack;
  logic [PC_W-1:0] ld_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic imem_req, fetch_busy, fetch_err;
  logic [PC_W-1:0] imem_addr, pc;
  logic [INSTR_W-1:0] instruction;

  int passed = 0, total = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .PC_clr(PC_clr), .PC_inc(PC_inc), .PC_ld(PC_ld),
    .ld_addr(ld_addr), .I_rd(I_rd), .IR_ld(IR_ld), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc(pc), .fetch_busy(fetch_busy), .fetch_err(fetch_err)
  );

  task automatic idle_inputs();
    rst = 0; PC_clr = 0; PC_inc = 0; PC_ld = 0; I_rd = 0; IR_ld = 0;
    imem_ack = 0; ld_addr = '0; imem_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs(); rst = 1; I_rd = 1; PC_inc = 1; imem_ack = 1;
    tick(); idle_inputs(); #1;
    total++; if ({pc, instruction} !== 24'h0) $display("FAIL reset_pc_ir got %h/%h want 0/0", pc, instruction); else passed++;
    total++; if ({imem_req, fetch_busy, fetch_err} !== 3'b000) $display("FAIL reset_flags got %b want 000", {imem_req, fetch_busy, fetch_err}); else passed++;
  endtask

  task automatic test_single_cycle();
    logic [INSTR_W-1:0] mem [3];
    mem[0] = 16'h0102; mem[1] = 16'h2345; mem[2] = 16'h3AFF;
    PC_clr = 1; tick(); idle_inputs();
    for (int i = 0; i < 3; i++) begin
      I_rd = 1; IR_ld = 1; PC_inc = 1; imem_ack = 1; imem_rdata = mem[i]; #1;
      total++; if ({imem_req, fetch_busy} !== 2'b10) $display("FAIL sc_busy[%0d] got req/busy %b want 10", i, {imem_req, fetch_busy}); else passed++;
      total++; if (imem_addr !== PC_W'(i)) $display("FAIL sc_addr[%0d] got %h want %h", i, imem_addr, i); else passed++;
      tick();
      total++; if (instruction !== mem[i]) $display("FAIL sc_ir[%0d] got %h want %h", i, instruction, mem[i]); else passed++;
      total++; if (pc !== PC_W'(i + 1)) $display("FAIL sc_pc[%0d] got %h want %h", i, pc, i + 1); else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_wait_states();
    PC_ld = 1; ld_addr = 8'h05; tick(); idle_inputs();
    I_rd = 1; IR_ld = 1; PC_inc = 1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin imem_ack = 1; imem_rdata = 16'h5300; end
      #1;
      total++; if (imem_req !== 1'b1 || imem_addr !== 8'h05) $display("FAIL ws_req[%0d] got req=%b addr=%h want 1/05", k, imem_req, imem_addr); else passed++;
      total++; if (fetch_busy !== (k < 3)) $display("FAIL ws_busy[%0d] got %b want %b", k, fetch_busy, k < 3); else passed++;
      tick();
      // latched flags must govern completion, so live controls are dropped in WAIT
      I_rd = 0; IR_ld = 0; PC_inc = 0;
    end
    total++; if (instruction !== 16'h5300 || pc !== 8'h06) $display("FAIL ws_done got ir=%h pc=%h want 5300/06", instruction, pc); else passed++;
    idle_inputs();
  endtask

  task automatic test_load_wrap();
    PC_ld = 1; ld_addr = 8'hFF; I_rd = 1; IR_ld = 1; PC_inc = 1; imem_ack = 1; #1;
    total++; if (imem_req !== 1'b0) $display("FAIL ld_noreq got %b want 0", imem_req); else passed++;
    tick(); idle_inputs();
    total++; if (pc !== 8'hFF) $display("FAIL ld_pc got %h want ff", pc); else passed++;
    I_rd = 1; IR_ld = 1; PC_inc = 1; imem_ack = 1; imem_rdata = 16'h7A55; #1;
    total++; if (imem_addr !== 8'hFF) $display("FAIL wrap_addr got %h want ff", imem_addr); else passed++;
    tick(); idle_inputs();
    total++; if (pc !== 8'h00 || instruction !== 16'h7A55) $display("FAIL wrap_pc got pc=%h ir=%h want 00/7a55", pc, instruction); else passed++;
  endtask

  task automatic test_abort();
    logic [INSTR_W-1:0] ir_before;
    PC_ld = 1; ld_addr = 8'h33; tick(); idle_inputs();
    ir_before = instruction;
    I_rd = 1; IR_ld = 1; PC_inc = 1; tick(); idle_inputs();
    PC_clr = 1; #1;
    total++; if (imem_req !== 1'b1) $display("FAIL abort_req_hold got %b want 1", imem_req); else passed++;
    tick(); idle_inputs();
    total++; if (pc !== 8'h00 || imem_req !== 1'b0) $display("FAIL abort_state got pc=%h req=%b want 00/0", pc, imem_req); else passed++;
    imem_ack = 1; imem_rdata = 16'hBEEF; #1;
    total++; if (fetch_busy !== 1'b0 || imem_req !== 1'b0) $display("FAIL stray_ack got busy=%b req=%b want 0/0", fetch_busy, imem_req); else passed++;
    tick(); idle_inputs();
    total++; if (instruction !== ir_before || pc !== 8'h00) $display("FAIL stray_ignored got ir=%h pc=%h want %h/00", instruction, pc, ir_before); else passed++;
  endtask

  task automatic test_reset_mid_wait();
    PC_ld = 1; ld_addr = 8'h07; tick(); idle_inputs();
    I_rd = 1; IR_ld = 1; imem_ack = 1; imem_rdata = 16'h1234; tick(); idle_inputs();
    total++; if (pc !== 8'h07 || instruction !== 16'h1234) $display("FAIL rmw_setup got pc=%h ir=%h want 07/1234", pc, instruction); else passed++;
    I_rd = 1; IR_ld = 1; PC_inc = 1; tick(); idle_inputs();
    rst = 1; tick(); idle_inputs(); #1;
    total++; if (pc !== 8'h00 || instruction !== 16'h0000) $display("FAIL rmw_regs got pc=%h ir=%h want 00/0000", pc, instruction); else passed++;
    total++; if (imem_req !== 1'b0 || fetch_busy !== 1'b0) $display("FAIL rmw_req got req=%b busy=%b want 0/0", imem_req, fetch_busy); else passed++;
  endtask

  task automatic test_timeout();
    PC_ld = 1; ld_addr = 8'h42; tick(); idle_inputs();
    I_rd = 1; IR_ld = 1; PC_inc = 1; tick(); idle_inputs();
`ifdef FETCH_TIMEOUT_EN
    for (int c = 1; c < TIMEOUT; c++) tick();
    total++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) $display("FAIL to_early got err=%b req=%b want 0/1", fetch_err, imem_req); else passed++;
    tick();
    total++; if (instruction !== 16'hFFFF || fetch_err !== 1'b1) $display("FAIL to_fire got ir=%h err=%b want ffff/1", instruction, fetch_err); else passed++;
    total++; if (pc !== 8'h42 || imem_req !== 1'b0) $display("FAIL to_idle got pc=%h req=%b want 42/0", pc, imem_req); else passed++;
    PC_clr = 1; tick(); idle_inputs();
    total++; if (fetch_err !== 1'b0) $display("FAIL to_clr got %b want 0", fetch_err); else passed++;
`else
    for (int c = 0; c < TIMEOUT + 5; c++) tick();
    total++; if (imem_req !== 1'b1 || fetch_err !== 1'b0 || pc !== 8'h42) $display("FAIL no_to got req=%b err=%b pc=%h want 1/0/42", imem_req, fetch_err, pc); else passed++;
    imem_ack = 1; imem_rdata = 16'h0F0F; tick(); idle_inputs();
    total++; if (instruction !== 16'h0F0F || pc !== 8'h43) $display("FAIL no_to_done got ir=%h pc=%h want 0f0f/43", instruction, pc); else passed++;
`endif
  endtask

  // Reference model: a fetch is a transaction that is either outstanding or not.
  task automatic test_random();
    logic [PC_W-1:0] m_pc; logic [INSTR_W-1:0] m_ir;
    logic outstanding, want_inc, want_ir, m_err, exp_req;
    int waited;
    idle_inputs(); rst = 1; tick();
    m_pc = '0; m_ir = '0; outstanding = 0; want_inc = 0; want_ir = 0; m_err = 0; waited = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0); PC_clr = ($urandom_range(0, 19) == 0);
      PC_ld = ($urandom_range(0, 9) == 0); ld_addr = PC_W'($urandom);
      I_rd = $urandom_range(0, 1); IR_ld = $urandom_range(0, 1); PC_inc = $urandom_range(0, 1);
      imem_ack = ($urandom_range(0, 3) == 0); imem_rdata = INSTR_W'($urandom);
      exp_req = outstanding || (!PC_clr && !PC_ld && I_rd);
      #1;
      total++; if (imem_req !== exp_req || fetch_busy !== (exp_req && !imem_ack) || imem_addr !== m_pc)
        $display("FAIL rnd_comb[%0d] got req=%b busy=%b addr=%h want %b/%b/%h", n, imem_req, fetch_busy, imem_addr, exp_req, exp_req && !imem_ack, m_pc);
      else passed++;
      if (rst) begin
        m_pc = '0; m_ir = '0; outstanding = 0; want_inc = 0; want_ir = 0; m_err = 0;
      end else if (PC_clr) begin
        m_pc = '0; outstanding = 0; m_err = 0;
      end else if (!outstanding && PC_ld) begin
        m_pc = ld_addr;
      end else if (exp_req) begin
        if (!outstanding) begin want_inc = PC_inc; want_ir = IR_ld; waited = 0; end
        if (imem_ack) begin
          if (want_ir) m_ir = imem_rdata;
          if (want_inc) m_pc = m_pc + 1'b1;
          outstanding = 0;
        end else if (!outstanding) begin
          outstanding = 1;
        end else begin
          waited++;
`ifdef FETCH_TIMEOUT_EN
          if (waited == TIMEOUT) begin m_ir = '1; m_err = 1; outstanding = 0; end
`endif
        end
      end
      tick();
      total++; if (pc !== m_pc || instruction !== m_ir || fetch_err !== m_err)
        $display("FAIL rnd_state[%0d] got pc=%h ir=%h err=%b want %h/%h/%b", n, pc, instruction, fetch_err, m_pc, m_ir, m_err);
      else passed++;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_cycle();
    test_wait_states();
    test_load_wrap();
    test_abort();
    test_reset_mid_wait();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream stage of the SimpleCPU controller FSM. Owns the program counter (PC) and the instruction register (IR).
- Fetches 16-bit instructions from a variable-latency instruction memory over a req/ack handshake.
- Drives `instruction` into the controller and raises `fetch_busy` so the controller holds in FETCH until the word is captured.
- With a single-cycle memory (ack in the request cycle), behaviour matches the original zero-wait PC/IR datapath exactly.

Parameters:
- PC_W, 8: PC and instruction-memory address width.
- INSTR_W, 16: instruction width.
- TIMEOUT, 15: WAIT cycles before a fetch error. Used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- PC_clr  in  1  clear PC; aborts any fetch in flight.
- PC_inc  in  1  increment PC when the current fetch completes.
- PC_ld  in  1  load PC from ld_addr.
- ld_addr  in  PC_W  jump target (controller supplies instruction[7:0]).
- I_rd  in  1  request an instruction fetch.
- IR_ld  in  1  capture the fetched word into IR.
- imem_req  out  1  memory request.
- imem_addr  out  PC_W  memory address (equals pc).
- imem_ack  in  1  memory data valid.
- imem_rdata  in  INSTR_W  memory read data.
- instruction  out  INSTR_W  IR contents, to the controller.
- pc  out  PC_W  current PC.
- fetch_busy  out  1  stall to the controller.
- fetch_err  out  1  sticky fetch timeout flag. Tied to 0 without FETCH_TIMEOUT_EN.

Behaviour:
- Reset (rst high at a clk edge):
  - pc=0, IR=0, state=IDLE.
  - imem_req=0, fetch_busy=0, fetch_err=0.
  - Latched flags inc_p and ld_p cleared.
  - rst overrides every other input.
- FSM has two states, IDLE and WAIT.
- IDLE, priority order:
  1. PC_clr: pc<=0, no fetch.
  2. PC_ld: pc<=ld_addr, no fetch. I_rd in the same cycle is ignored.
  3. I_rd: launch a fetch.
     - imem_req=1 combinationally; inc_p<=PC_inc; ld_p<=IR_ld.
     - If imem_ack is high in the same cycle: complete immediately (see completion), stay in IDLE.
     - Otherwise go to WAIT.
- WAIT:
  - imem_req=1, imem_addr=pc; both held stable.
  - PC_inc, IR_ld and I_rd are ignored; the latched flags govern.
  - PC_ld in WAIT is a protocol violation and is ignored.
  - PC_clr aborts: pc<=0, IR unchanged, go to IDLE, imem_req drops next cycle.
  - imem_ack: complete, go to IDLE.
- Completion, at the ack edge:
  - If the IR-load flag is set, IR<=imem_rdata.
  - If the increment flag is set, pc<=pc+1, wrapping modulo 2^PC_W (pc=255 goes to 0).
  - In the same-cycle-ack case the flags are the live inputs; in WAIT they are the latched values.
- Outputs:
  - fetch_busy = imem_req & ~imem_ack (combinational). A 1-cycle memory therefore never stalls.
  - imem_addr = pc at all times.
  - instruction = IR, registered.
  - imem_ack is ignored whenever imem_req=0, including a late ack after an abort.
- Fetch latency is 1 + memory wait cycles. Back-to-back fetches need no idle cycle.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT: IR<=all ones (opcode 4'hF, driving the controller to ERROR), pc unchanged, state<=IDLE, fetch_err<=1.
  - fetch_err is sticky until rst or PC_clr.
  - An ack in the same cycle as the timeout takes priority and the fetch completes normally.
- Undefined: no counter, fetch_err=0, WAIT persists until ack or PC_clr.

Test Plan:
- Reset, then PC_clr, then a 1-cycle memory with I_rd=IR_ld=PC_inc=1 for 3 cycles (mem[0..2]=16'h0102,16'h2345,16'h3AFF) -> IR sequence 0102, 2345, 3AFF; pc 0→1→2→3; fetch_busy never high.
- Memory acks 3 cycles after request, mem[5]=16'h5300 with pc=5 -> imem_req high 4 cycles, addr stable at 5; fetch_busy high 3 cycles; IR=5300 and pc=6 on the ack edge.
- PC_ld=1 with ld_addr=8'hFF and I_rd=1 in the same cycle -> pc=FF, no request issued. Next fetch -> addr FF, pc wraps to 00.
- Fetch pending in WAIT, PC_clr pulsed, then a stray ack one cycle later -> pc=0, IR unchanged, state IDLE, stray ack ignored.
- rst asserted mid-WAIT with pc=7 and IR=16'h1234 -> next cycle pc=0, IR=0, imem_req=0, fetch_busy=0.
- (FETCH_TIMEOUT_EN, TIMEOUT=15) no ack for 15 cycles -> IR=FFFF, fetch_err=1, pc unchanged, IDLE. PC_clr -> fetch_err=0.
